acc_pixel_map: RTL and testbench



---
 rtl/acc_pkg.sv | 12 +
 rtl/pixel_map.sv | 15 +
 rtl/acc_pixel_map.sv | 78 +++++++
 tb/tb_acc_pixel_map.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared image geometry, word/address types and FSM states for image accelerators.
package acc_pkg;
    localparam int IMG_WIDTH       = 352;
    localparam int IMG_HEIGHT      = 288;
    localparam int WORDS_PER_IMAGE = IMG_WIDTH * IMG_HEIGHT / 4;
    localparam int RESULT_OFFSET   = WORDS_PER_IMAGE;

    typedef logic [31:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/pixel_map.sv
// pixel_map: bytewise greyscale map of one word; THRESHOLD 0 inverts, otherwise binarizes at p >= THRESHOLD.
module pixel_map
    import acc_pkg::*;
#(
    parameter int THRESHOLD = 0
) (
    input  word_t pix_i,
    output word_t pix_o
);
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] p;
        assign p = pix_i[8*k +: 8];
        assign pix_o[8*k +: 8] = (THRESHOLD == 0) ? ~p : ((p >= 8'(THRESHOLD)) ? 8'hFF : 8'h00);
    end
endmodule

// File: rtl/acc_pixel_map.sv
// acc_pixel_map: image RAM master that reads each input word, maps its pixels and writes the result image.
module acc_pixel_map #(
    parameter int WORDS_PER_IMAGE = acc_pkg::WORDS_PER_IMAGE,
    parameter int RESULT_OFFSET   = acc_pkg::RESULT_OFFSET,
    parameter int THRESHOLD       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          finish,
    output logic          en,
    output logic          we,
    output acc_pkg::addr_t addr,
    output acc_pkg::word_t dataW,
    input  acc_pkg::word_t dataR
);
    import acc_pkg::*;

    localparam addr_t LAST = addr_t'(WORDS_PER_IMAGE - 1);
    localparam addr_t OFF  = addr_t'(RESULT_OFFSET);

    state_t state_q;
    addr_t  cnt_q, addr_q;
    logic   en_q, we_q, fin_q;
    word_t  mapped;

    pixel_map #(.THRESHOLD(THRESHOLD)) u_map (.pix_i(dataR), .pix_o(mapped));

    // Control outputs are registered on state entry; write data is taken straight from the
    // registered RAM read so each word costs one read cycle plus one write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= READ;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                    en_q    <= 1'b1;
                    we_q    <= 1'b0;
                end
                READ: begin
                    state_q <= WRITE;
                    we_q    <= 1'b1;
                    addr_q  <= cnt_q + OFF;
                end
                WRITE: if (cnt_q == LAST) begin
                    state_q <= DONE;
                    en_q    <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    fin_q   <= 1'b1;
                end else begin
                    state_q <= READ;
                    cnt_q   <= cnt_q + 16'd1;
                    addr_q  <= cnt_q + 16'd1;
                    we_q    <= 1'b0;
                end
                DONE: if (!start) begin
                    state_q <= IDLE;
                    fin_q   <= 1'b0;
                end
            endcase
        end
    end

    assign en     = en_q;
    assign we     = we_q;
    assign addr   = addr_q;
    assign finish = fin_q;
    assign dataW  = we_q ? mapped : '0;
endmodule

// File: tb/tb_acc_pixel_map.sv
// tb_acc_pixel_map: scoreboard bench; a full default-size inverting pass plus a small thresholding instance
// used for hold-in-DONE, restart, one-cycle start pulse and mid-image asynchronous reset.
module tb_acc_pixel_map;
    import acc_pkg::*;

    localparam int WB = 8;
    localparam int OB = 8;
    localparam word_t TA_IN[4]  = '{32'h00FF_7F01, 32'h807F_00FF, 32'h1234_5678, 32'hDEAD_BEEF};
    localparam word_t TA_OUT[4] = '{32'hFF00_80FE, 32'h7F80_FF00, 32'hEDCB_A987, 32'h2152_4110};
    localparam word_t TB_IN[4]  = '{32'h807F_00FF, 32'h7F80_807F, 32'hDEAD_BEEF, 32'h00FF_7F01};
    localparam word_t TB_OUT[4] = '{32'hFF00_00FF, 32'h00FF_FF00, 32'hFFFF_FFFF, 32'h00FF_0000};

    typedef struct packed {addr_t a; word_t d;} exp_t;

    logic  clk = 1'b0;
    logic  rst_a_n, rst_b_n, start_a, start_b;
    logic  finish_a, en_a, we_a, finish_b, en_b, we_b;
    addr_t addr_a, addr_b;
    word_t dataW_a, dataR_a, dataW_b, dataR_b;
    word_t mem_a[0:2*WORDS_PER_IMAGE-1];
    word_t mem_b[0:WB+OB-1];
    exp_t  qa[$], qb[$];
    exp_t  ea, eb;
    bit    pa = 1'b0, pb = 1'b0;
    int    checks = 0, passes = 0;
    int    n, k;

    always #5 clk = ~clk;

    acc_pixel_map u_a (
        .clk(clk), .rst_n(rst_a_n), .start(start_a), .finish(finish_a),
        .en(en_a), .we(we_a), .addr(addr_a), .dataW(dataW_a), .dataR(dataR_a)
    );

    acc_pixel_map #(.WORDS_PER_IMAGE(WB), .RESULT_OFFSET(OB), .THRESHOLD(128)) u_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .finish(finish_b),
        .en(en_b), .we(we_b), .addr(addr_b), .dataW(dataW_b), .dataR(dataR_b)
    );

    always @(posedge clk) begin
        if (en_a && we_a) mem_a[addr_a] <= dataW_a;
        else if (en_a) dataR_a <= mem_a[addr_a];
        if (en_b && we_b) mem_b[addr_b] <= dataW_b;
        else if (en_b) dataR_b <= mem_b[addr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_a_n && en_a && we_a) begin
            chk("a_write_after_read", 32'(pa), 1);
            if (qa.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_write: addr %h data %h, expected no write", addr_a, dataW_a);
            end else begin
                ea = qa.pop_front();
                chk("a_waddr", 32'(addr_a), 32'(ea.a));
                chk("a_wdata", dataW_a, ea.d);
            end
        end else if (rst_a_n && en_a) chk("a_read_range", 32'(addr_a < WORDS_PER_IMAGE), 1);
        pa = en_a && !we_a;
    end

    always @(negedge clk) begin
        if (rst_b_n && en_b && we_b) begin
            chk("b_write_after_read", 32'(pb), 1);
            if (qb.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_write: addr %h data %h, expected no write", addr_b, dataW_b);
            end else begin
                eb = qb.pop_front();
                chk("b_waddr", 32'(addr_b), 32'(eb.a));
                chk("b_wdata", dataW_b, eb.d);
            end
        end else if (rst_b_n && en_b) chk("b_read_range", 32'(addr_b < WB), 1);
        pb = en_b && !we_b;
    end

    task automatic push_b();
        for (int i = 0; i < WB; i++) begin
            qb.push_back('{addr_t'(OB + i), TB_OUT[i%4]});
            mem_b[OB+i] = '0;
        end
    endtask

    // Raise start at a falling edge; n counts cycles after the sampling edge until finish is seen.
    task automatic run(input bit b, input bit pulse, output int cyc);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        if (pulse) begin
            #1;
            start_b = 1'b0;
        end
        for (cyc = 1; cyc <= 60000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk(b ? "b_first_read" : "a_first_read",
                              b ? 32'({en_b, we_b, addr_b}) : 32'({en_a, we_a, addr_a}), 32'h2_0000);
            if (b ? finish_b : finish_a) break;
        end
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < WORDS_PER_IMAGE; i++) begin
            mem_a[i] = TA_IN[i%4];
            mem_a[WORDS_PER_IMAGE+i] = '0;
        end
        for (int i = 0; i < WB; i++) mem_b[i] = TB_IN[i%4];
        repeat (2) @(negedge clk);
        chk("a_reset_ctl", 32'({en_a, we_a, finish_a}), 0);
        chk("a_reset_addr", 32'(addr_a), 0);
        chk("a_reset_dataW", dataW_a, 0);
        chk("b_reset_ctl", 32'({en_b, we_b, finish_b}), 0);
        chk("b_reset_addr", 32'(addr_b), 0);
        chk("b_reset_dataW", dataW_b, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < WORDS_PER_IMAGE; i++) qa.push_back('{addr_t'(RESULT_OFFSET + i), TA_OUT[i%4]});
        run(1'b0, 1'b0, n);
        chk("a_finish_cycle", n, 2 * WORDS_PER_IMAGE + 1);
        chk("a_result_first", mem_a[RESULT_OFFSET], 32'hFF00_80FE);
        chk("a_result_last", mem_a[RESULT_OFFSET+WORDS_PER_IMAGE-1], 32'h2152_4110);
        start_a = 1'b0;
        @(negedge clk);
        chk("a_finish_fall", 32'(finish_a), 0);
        chk("a_all_written", qa.size(), 0);

        push_b();
        run(1'b1, 1'b0, n);
        chk("b_finish_cycle", n, 2 * WB + 1);
        chk("b_result_0", mem_b[OB], 32'hFF00_00FF);
        chk("b_result_1", mem_b[OB+1], 32'h00FF_FF00);
        repeat (5) begin
            @(negedge clk);
            chk("b_hold_done", 32'({en_b, finish_b}), 32'b01);
        end
        start_b = 1'b0;
        @(negedge clk);
        chk("b_finish_fall", 32'(finish_b), 0);
        chk("b_all_written", qb.size(), 0);

        @(negedge clk);
        push_b();
        run(1'b1, 1'b0, n);
        chk("b_second_pass_cycle", n, 2 * WB + 1);
        start_b = 1'b0;
        @(negedge clk);
        chk("b_second_pass_done", qb.size(), 0);

        @(negedge clk);
        push_b();
        run(1'b1, 1'b1, n);
        chk("b_pulse_cycle", n, 2 * WB + 1);
        @(negedge clk);
        chk("b_pulse_finish_1cyc", 32'(finish_b), 0);
        chk("b_pulse_all_written", qb.size(), 0);
        chk("b_pulse_result_7", mem_b[OB+7], 32'h00FF_0000);

        @(negedge clk);
        push_b();
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (en_b && !we_b && addr_b == 16'd3) break;
        end
        chk("b_reach_word3", 32'(k < 100), 1);
        rst_b_n = 1'b0;
        #1;
        chk("b_async_rst_ctl", 32'({en_b, we_b, finish_b}), 0);
        chk("b_async_rst_addr", 32'(addr_b), 0);
        chk("b_async_rst_dataW", dataW_b, 0);
        qb.delete();
        @(negedge clk);
        rst_b_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("b_idle_after_rst", 32'({en_b, finish_b}), 0);
        end
        push_b();
        run(1'b1, 1'b0, n);
        chk("b_restart_cycle", n, 2 * WB + 1);
        chk("b_restart_result_0", mem_b[OB], 32'hFF00_00FF);
        chk("b_restart_result_6", mem_b[OB+6], 32'hFFFF_FFFF);
        start_b = 1'b0;
        @(negedge clk);
        chk("b_restart_all_written", qb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
